// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one bitwise logic unit between two requesters.
// Optional per-requester completion counters are enabled with LOGIC_ARB_STATS_EN.
module logic_unit_arbiter #(
  parameter int WIDTH = 8
`ifdef LOGIC_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  input  logic [WIDTH-1:0] fu_and,
  input  logic [WIDTH-1:0] fu_or,
  input  logic [WIDTH-1:0] fu_not,
  input  logic [WIDTH-1:0] fu_nand,
  input  logic [WIDTH-1:0] fu_nor,
  input  logic [WIDTH-1:0] fu_xor,
  input  logic [WIDTH-1:0] fu_xnor,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
`ifdef LOGIC_ARB_STATS_EN
  , output logic [CNT_W-1:0] cnt0
  , output logic [CNT_W-1:0] cnt1
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic gnt, last_grant, hs;
  logic [2:0] op_q;
  logic [WIDTH-1:0] res;
  // last_grant doubles as the owner ID of the operation in flight
  always_comb gnt = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (hs ? BUSY : IDLE) : (state == BUSY) ? DONE : IDLE;
  always_comb begin
    req0_ready = state == IDLE && rst_n && !gnt && req0_valid;
    req1_ready = state == IDLE && rst_n && gnt && req1_valid;
    hs = req0_ready || req1_ready;
    rsp_valid = state == DONE;
  end
  always_comb begin
    res = '0;
    case (op_q)
      3'd0: res = fu_and;
      3'd1: res = fu_or;
      3'd2: res = fu_not;
      3'd3: res = fu_nand;
      3'd4: res = fu_nor;
      3'd5: res = fu_xor;
      3'd6: res = fu_xnor;
      default: res = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_q <= '0;
      fu_a <= '0;
      fu_b <= '0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else if (hs) begin
      last_grant <= gnt;
      op_q <= gnt ? req1_op : req0_op;
      fu_a <= gnt ? req1_a : req0_a;
      fu_b <= gnt ? req1_b : req0_b;
    end else if (state == BUSY) begin
      rsp_id <= last_grant;
      rsp_data <= res;
      rsp_err <= op_q == 3'd7;
    end
`ifdef LOGIC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (state == BUSY) begin
      if (!last_grant && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
      if (last_grant && cnt1 != '1) cnt1 <= cnt1 + 1'b1;
    end
`endif
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: vector table, corner sequences and a randomized model check.
module tb_logic_unit_arbiter;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [7:0] fu_a, fu_b, fu_and, fu_or, fu_not, fu_nand, fu_nor, fu_xor, fu_xnor, rsp_data;
  logic rsp_valid, rsp_id, rsp_err;
`ifdef LOGIC_ARB_STATS_EN
  logic [1:0] cnt0, cnt1;
`endif
  assign fu_and = fu_a & fu_b;
  assign fu_or = fu_a | fu_b;
  assign fu_not = ~fu_a;
  assign fu_nand = ~(fu_a & fu_b);
  assign fu_nor = ~(fu_a | fu_b);
  assign fu_xor = fu_a ^ fu_b;
  assign fu_xnor = ~(fu_a ^ fu_b);
  logic_unit_arbiter #(.WIDTH(8)
`ifdef LOGIC_ARB_STATS_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .fu_a(fu_a), .fu_b(fu_b), .fu_and(fu_and), .fu_or(fu_or), .fu_not(fu_not), .fu_nand(fu_nand),
    .fu_nor(fu_nor), .fu_xor(fu_xor), .fu_xnor(fu_xnor),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
`ifdef LOGIC_ARB_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, ~a};
      3'd3: return {1'b0, ~(a & b)};
      3'd4: return {1'b0, ~(a | b)};
      3'd5: return {1'b0, a ^ b};
      3'd6: return {1'b0, ~(a ^ b)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction
  task automatic set_req(input logic id, input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    @(negedge clk);
    chk("rst_outs", {fu_a, fu_b, rsp_data, rsp_valid, rsp_id, rsp_err}, 0);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic run_op(input logic id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] d, output logic e, output logic rid);
    logic got = 0;
    d = 0; e = 0; rid = 0;
    @(negedge clk);
    set_req(id, 1, op, a, b);
    set_req(!id, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin got = 1; break; end
      @(negedge clk);
    end
    chk("ready_wait", got, 1);
    if (!got) begin set_req(id, 0, 0, 0, 0); return; end
    @(posedge clk);
    #1 set_req(id, 0, op, ~a, ~b);
    @(negedge clk);
    chk("fu_ab_loaded", {fu_a, fu_b}, {a, b});
    chk("busy_no_valid", rsp_valid, 0);
    @(negedge clk);
    chk("done_valid", rsp_valid, 1);
    d = rsp_data; e = rsp_err; rid = rsp_id;
    @(negedge clk);
    chk("valid_drop", rsp_valid, 0);
    chk("rsp_hold", {rsp_data, rsp_err, rsp_id}, {d, e, rid});
  endtask
  typedef struct {logic id; logic [2:0] op; logic [7:0] a, b, data; logic err;} vec_t;
  vec_t vt[8];
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [7:0] d; logic e, rid;
    vt[0] = '{0, 3'd0, 8'hF0, 8'h3C, 8'h30, 0};
    vt[1] = '{1, 3'd1, 8'hA5, 8'h0F, 8'hAF, 0};
    vt[2] = '{0, 3'd2, 8'hA5, 8'h0F, 8'h5A, 0};
    vt[3] = '{1, 3'd3, 8'hA5, 8'h0F, 8'hFA, 0};
    vt[4] = '{0, 3'd4, 8'hA5, 8'h0F, 8'h50, 0};
    vt[5] = '{1, 3'd5, 8'hA5, 8'h0F, 8'hAA, 0};
    vt[6] = '{0, 3'd6, 8'hA5, 8'h0F, 8'h55, 0};
    vt[7] = '{1, 3'd7, 8'hA5, 8'h0F, 8'h00, 1};
    do_reset();
    foreach (vt[i]) begin
      run_op(vt[i].id, vt[i].op, vt[i].a, vt[i].b, d, e, rid);
      chk($sformatf("vec%0d_data", i), d, vt[i].data);
      chk($sformatf("vec%0d_err", i), e, vt[i].err);
      chk($sformatf("vec%0d_id", i), rid, vt[i].id);
    end
    begin
      int hs_n = 0, rs_n = 0, last_hs = -10;
      logic q[$];
      set_req(0, 1, 3'd5, 8'h3C, 8'h99);
      set_req(1, 1, 3'd5, 8'hC3, 8'h0F);
      do_reset();
      for (int c = 0; c < 12; c++) begin
        #1;
        chk("cont_onehot", req0_ready && req1_ready, 0);
        if (req0_ready || req1_ready) begin
          chk("cont_grant", req1_ready, hs_n % 2);
          if (hs_n == 0) chk("cont_first", c, 0);
          else chk("cont_gap", c - last_hs, 3);
          q.push_back(req1_ready);
          last_hs = c; hs_n++;
        end
        if (rsp_valid && q.size() > 0) begin
          chk("cont_rsp_id", rsp_id, q[0]);
          chk("cont_rsp_data", rsp_data, q[0] ? 8'hCC : 8'hA5);
          void'(q.pop_front());
          rs_n++;
        end
        @(negedge clk);
      end
      chk("cont_hs_count", hs_n, 4);
      chk("cont_rsp_count", rs_n, 4);
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
    end
    do_reset();
    set_req(0, 1, 3'd0, 8'h12, 8'h34);
    set_req(1, 1, 3'd1, 8'h56, 8'h78);
    #1 chk("mid_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_ready1", req1_ready, 0);
    chk("mid_rst_outs", {fu_a, fu_b, rsp_data, rsp_valid, rsp_id, rsp_err}, 0);
    @(negedge clk);
    chk("mid_no_valid", rsp_valid, 0);
    rst_n = 1;
    #1 chk("mid_release_ready1", req1_ready, 1);
    @(posedge clk);
    #1 req1_valid = 0;
    @(negedge clk);
    chk("mid_fu", {fu_a, fu_b}, 16'h5678);
    @(negedge clk);
    chk("mid_rsp", {rsp_valid, rsp_id, rsp_data, rsp_err}, {1'b1, 1'b1, 8'h7E, 1'b0});
`ifdef LOGIC_ARB_STATS_EN
    do_reset();
    chk("cnt_reset", {cnt0, cnt1}, 0);
    for (int i = 0; i < 5; i++) begin
      run_op(1, (i == 2) ? 3'd7 : 3'd5, 8'(i), 8'h11, d, e, rid);
      if (i == 0) chk("cnt1_one", cnt1, 1);
    end
    run_op(0, 3'd0, 8'hFF, 8'h0F, d, e, rid);
    chk("cnt1_sat", cnt1, 3);
    chk("cnt0_one", cnt0, 1);
`endif
    begin
      int wait_c = 0;
      logic mlast = 1, mg, er0, er1, pend_id = 0, hold_id = 0;
      logic [7:0] efa = 0, efb = 0;
      logic [8:0] pend = 0, hold = 0, exp_r;
      logic ex_id;
      do_reset();
      for (int c = 0; c < 400; c++) begin
        set_req(0, $urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        set_req(1, $urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        #1;
        mg = (req0_valid && req1_valid) ? !mlast : req1_valid;
        er0 = wait_c == 0 && req0_valid && !mg;
        er1 = wait_c == 0 && req1_valid && mg;
        exp_r = (wait_c == 1) ? pend : hold;
        ex_id = (wait_c == 1) ? pend_id : hold_id;
        chk("rnd_ready0", req0_ready, er0);
        chk("rnd_ready1", req1_ready, er1);
        chk("rnd_valid", rsp_valid, wait_c == 1);
        chk("rnd_fu", {fu_a, fu_b}, {efa, efb});
        chk("rnd_rsp", {rsp_err, rsp_data, rsp_id}, {exp_r, ex_id});
        if (wait_c == 1) begin hold = pend; hold_id = pend_id; end
        if (wait_c > 0) wait_c--;
        else if (er0 || er1) begin
          wait_c = 2;
          mlast = mg;
          pend_id = mg;
          efa = mg ? req1_a : req0_a;
          efb = mg ? req1_b : req0_b;
          pend = ref_op(mg ? req1_op : req0_op, efa, efb);
        end
        @(negedge clk);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one combinational bitwise logic unit between two requesters. The unit computes AND, OR, NOT, NAND, NOR, XOR and XNOR of two operands. The arbiter accepts one operation at a time over a valid/ready handshake and drives the shared unit's operand inputs. It then selects the requested function output and returns the result on a common response bus tagged with the requester ID.

## Interface
- WIDTH, 8, operand and result width in bits
- CNT_W, 16, width of each completed-operation counter (used only with LOGIC_ARB_STATS_EN)

Ports. Clock is a single clock, `clk`. Reset is `rst_n`, asynchronous and active-low.
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  3  requester 0 opcode
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0
- fu_a  output  WIDTH  operand A to the shared logic unit, registered
- fu_b  output  WIDTH  operand B to the shared logic unit, registered
- fu_and, fu_or, fu_not, fu_nand, fu_nor, fu_xor, fu_xnor  input  WIDTH each  function outputs from the shared unit
- rsp_valid  output  1  single-cycle response strobe
- rsp_id  output  1  requester that owns the response
- rsp_data  output  WIDTH  result
- rsp_err  output  1  the opcode was illegal
- cnt0, cnt1  output  CNT_W each  completed operations per requester; present only with LOGIC_ARB_STATS_EN

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 NOT (of A; B ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
  - 7 is illegal: rsp_data = 0 and rsp_err = 1.
- State machine has three states: IDLE, BUSY, DONE.
  - IDLE: grant logic is active. A handshake (valid && ready on the granted port) latches op, a, b and the ID. fu_a and fu_b load a and b. Next state is BUSY. Otherwise stay in IDLE.
  - BUSY: fu_a and fu_b hold. The function output selected by the latched op is registered into rsp_data, and rsp_err is set on an illegal op. Next state is DONE.
  - DONE: rsp_valid = 1 with rsp_id driven. Next state is IDLE unconditionally.
- Grant rules:
  - readyN is combinational: state == IDLE && rst_n && granted == N && reqN_valid.
  - Only one ready is high per cycle.
  - With a single valid, that requester wins.
  - With both valid, the requester other than last_grant wins.
  - last_grant updates on every handshake.
- Responses have no backpressure; a requester must accept rsp_valid whenever it is asserted.
- fu_a and fu_b hold their last values outside BUSY.

## Timing
- Handshake at edge N:
  - fu_a and fu_b are valid after edge N.
  - rsp_data and rsp_err are registered at edge N+1.
  - rsp_valid is high from edge N+1 to edge N+2.
  - The next handshake is possible at edge N+2 or later.
- Throughput: one operation per 3 cycles.
- rsp_data, rsp_id and rsp_err hold their value after rsp_valid drops, until the next capture.
- Reset values:
  - state IDLE; last_grant = 1, so requester 0 wins the first contention.
  - fu_a = fu_b = 0; rsp_valid = 0; rsp_id = 0; rsp_data = 0; rsp_err = 0; cnt0 = cnt1 = 0.
  - Both ready outputs are 0 while rst_n is low.
- Reset asserted in BUSY or DONE aborts the operation: no rsp_valid is issued and counters are not incremented. After reset release, the first handshake can happen on the first clock edge.
- Input changes while a requester is not being accepted are ignored. Operands are sampled only at the handshake edge.

## Configuration
- `LOGIC_ARB_STATS_EN` defined:
  - Adds cnt0 and cnt1.
  - The counter selected by rsp_id increments when the DONE state is entered; the count includes ops that complete with rsp_err set.
  - Each counter saturates at 2^CNT_W - 1.
  - Counters reset to 0.
- Not defined: no counters and no cnt0/cnt1 ports. All other behaviour is identical.

## Test plan
- Single request:
  - Stimulus: req0 op=0, a=8'hF0, b=8'h3C, handshake at edge N.
  - Response: fu_a = 8'hF0 after edge N; rsp_valid high in the cycle after edge N+1 with rsp_data = 8'h30, rsp_id = 0, rsp_err = 0.
- Opcode sweep:
  - Stimulus: a=8'hA5, b=8'h0F, ops 1–6 in turn.
  - Response: OR 8'hAF, NOT 8'h5A, NAND 8'hFA, NOR 8'h50, XOR 8'hAA, XNOR 8'h55.
- Illegal opcode:
  - Stimulus: op=7.
  - Response: rsp_data = 0 and rsp_err = 1.
- Contention:
  - Stimulus: both requesters valid continuously from reset, op XOR.
  - Response: grants go 0,1,0,1; handshakes are 3 cycles apart; each response rsp_id matches its grant.
- Reset mid-operation:
  - Stimulus: rst_n pulsed low during BUSY.
  - Response: no rsp_valid; all outputs at reset values; a pending req1 is accepted on the first edge after release.
- Counter saturation:
  - Setup: `LOGIC_ARB_STATS_EN` defined and CNT_W=2.
  - Stimulus: 5 completed ops from req1 (one of them op=7), 1 completed op from req0.
  - Response: cnt1 = 3 (saturated), cnt0 = 1.
